hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline interlock controller for the RD->EX boundary. Drives stall/flush/bubble controls into the PC, IF/ID and RD/EX registers.
//  Inserts bubbles on load-use hazards and flushes younger stages on EX-resolved control transfers.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  LOAD_USE_STALLS  1   bubbles per load-use hazard; legal range 1..7
//  CNT_W            16  width of the stall_count and flush_count counters
// PORTS
//  clk            in   1      rising-edge clock; single clock domain
//  rst_n          in   1      synchronous reset, active-low
//  valid_rd       in   1      RD stage holds a real instruction
//  rs1_rd         in   3      RD source register A index
//  rs2_rd         in   3      RD source register B index
//  rs1_used_rd    in   1      RD instruction reads rs1_rd
//  rs2_used_rd    in   1      RD instruction reads rs2_rd
//  memread_ex     in   1      EX instruction is a load
//  regwrite_ex    in   1      EX instruction writes the register file
//  regdst_ex      in   3      EX destination register index
//  branch_taken_ex in  1      EX resolved a taken branch/jump, or a write to R7
//  pc_stall       out  1      hold PC
//  ifid_stall     out  1      hold IF/ID register
//  ifid_flush     out  1      load IF/ID with a NOP
//  rdex_bubble    out  1      load RD/EX with zeroed controls (regwrite/memwrite/memread/branch = 0)
//  stall_count    out  CNT_W  cycles with pc_stall=1, saturating
//  flush_count    out  CNT_W  cycles with ifid_flush=1, saturating
// BEHAVIOUR
//  States: RUN, STALL. State register, remaining-stall counter rem[2:0], and event counters update on posedge clk only.
//  Outputs are Mealy: combinational from state, rem and the current inputs.
//  Reset (rst_n=0 sampled at an edge): next state=RUN, rem=0, stall_count=0, flush_count=0.
//   While rst_n=0: ifid_flush=1, rdex_bubble=1, pc_stall=0, ifid_stall=0.
//   Reset overrides everything, including mid-STALL. The counters do not count reset cycles.
//  load_use = valid_rd & memread_ex & regwrite_ex & ((rs1_used_rd & rs1_rd==regdst_ex) | (rs2_used_rd & rs2_rd==regdst_ex)).
//  Priority each cycle: branch_taken_ex > STALL state > load_use > idle.
//  RUN, branch_taken_ex=1:
//   - ifid_flush=1, rdex_bubble=1, no stall.
//   - Stay in RUN. Any coincident load_use is discarded; RD is being flushed.
//  RUN, load_use=1:
//   - pc_stall=1, ifid_stall=1, rdex_bubble=1.
//   - If LOAD_USE_STALLS==1: stay in RUN.
//   - Else: go to STALL with rem=LOAD_USE_STALLS-1.
//  RUN, neither: all four controls 0.
//  STALL:
//   - pc_stall=1, ifid_stall=1, rdex_bubble=1 unconditionally. The hazard check is not re-evaluated.
//   - rem decrements each cycle. When rem==1 the next state is RUN.
//   - If branch_taken_ex=1 in STALL: behave as RUN+branch and go to RUN, rem=0.
//  A load_use stall therefore lasts exactly LOAD_USE_STALLS cycles.
//  ifid_stall and ifid_flush are never 1 together. When both would apply, flush wins.
//  Counters:
//   - stall_count+=1 on each non-reset cycle with pc_stall=1.
//   - flush_count+=1 on each non-reset cycle with ifid_flush=1.
//   - Both hold at all-ones (no wrap).
//  Register index R0 is not special: a match on R0 still stalls.
//  Latency: hazard detection to control outputs is 0 cycles, combinational within the same cycle.
// TESTING
//  1. memread_ex=1, regwrite_ex=1, regdst_ex=3, rs1_rd=3, rs1_used_rd=1, valid_rd=1 for 1 cycle
//     -> pc_stall=ifid_stall=rdex_bubble=1 for exactly 1 cycle; stall_count=1.
//  2. LOAD_USE_STALLS=3, same stimulus as 1
//     -> stalls held for 3 consecutive cycles; stall_count=3; state returns to RUN.
//  3. Same as 1 with rs1_used_rd=0 and rs2_rd=3, rs2_used_rd=0, or with valid_rd=0
//     -> no stall; stall_count stays 0.
//  4. load_use and branch_taken_ex=1 in the same cycle
//     -> ifid_flush=1, rdex_bubble=1, pc_stall=0; flush_count=1, stall_count=0.
//  5. LOAD_USE_STALLS=4, rst_n driven 0 during the 2nd STALL cycle
//     -> next edge: state=RUN, counters=0; while rst_n=0: ifid_flush=1, rdex_bubble=1.
//  6. CNT_W=4, 20 back-to-back load-use hazards
//     -> stall_count saturates at 4'hF and holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RD->EX pipeline interlock controller.
// Detects load-use hazards and inserts LOAD_USE_STALLS bubbles, flushes the
// younger stages on EX-resolved control transfers, and keeps saturating
// stall/flush event counters for performance debug.
module hazard_ctrl #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_rd,
    input  logic [2:0]       rs1_rd,
    input  logic [2:0]       rs2_rd,
    input  logic             rs1_used_rd,
    input  logic             rs2_used_rd,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    input  logic [2:0]       regdst_ex,
    input  logic             branch_taken_ex,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             rdex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0] EXTRA_STALLS = 3'(LOAD_USE_STALLS - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] rem;
    logic [2:0] next_rem;
    logic       load_use;

    // A load in EX whose destination is read by a valid RD instruction.
    always_comb begin
        load_use = valid_rd & memread_ex & regwrite_ex &
                   ((rs1_used_rd & (rs1_rd == regdst_ex)) |
                    (rs2_used_rd & (rs2_rd == regdst_ex)));
    end

    // Mealy control outputs and next state: reset > branch > STALL > load_use > idle.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        rdex_bubble = 1'b0;
        next_state  = state;
        next_rem    = rem;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            rdex_bubble = 1'b1;
            next_state  = RUN;
            next_rem    = 3'd0;
        end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            rdex_bubble = 1'b1;
            next_state  = RUN;
            next_rem    = 3'd0;
        end else if (state == STALL) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            rdex_bubble = 1'b1;
            if (rem <= 3'd1) begin
                next_state = RUN;
                next_rem   = 3'd0;
            end else begin
                next_rem   = rem - 3'd1;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            rdex_bubble = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                next_state = STALL;
                next_rem   = EXTRA_STALLS;
            end
        end
    end

    // State and remaining-stall register; reset returns to RUN even mid-stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    // Saturating event counters; reset cycles are never counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (pc_stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (ifid_flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
